nibble_serial_add_ctrl: RTL and testbench
=========================================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width, legal values multiples of 4 from 4 to 64.
REQ-002 The block SHALL have derived constant NIBBLES = WIDTH/4, the number of adder passes per operation.
REQ-003 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  request carries valid operands.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 sub  input  1  0 = A+B, 1 = A-B (two's complement).
REQ-011 out_valid  output  1  result fields valid.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of MSB nibble (for sub: 1 = no borrow).
REQ-015 overflow  output  1  signed overflow of the operation.
REQ-016 busy  output  1  high in RUN or DONE.

Function
REQ-017 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE: in_ready=1; on in_valid, the block SHALL capture a, b, sub, set carry register to sub, clear nibble counter, and go to RUN.
REQ-019 RUN: each cycle, the block SHALL add nibble k of A, nibble k of (B XOR {WIDTH{sub}}), and carry register, write the 4-bit result into sum bits [4k+3:4k], update the carry register, and increment k.
REQ-020 After nibble NIBBLES-1 is processed, the block SHALL go to DONE, latching cout = final carry and overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the inverted-or-not B.
REQ-021 out_valid SHALL rise exactly NIBBLES clock edges after the accepting edge (8 for WIDTH=32).
REQ-022 DONE: out_valid=1; sum, cout, and overflow SHALL stay stable until out_ready=1 is sampled, after which the state SHALL return to IDLE on that edge.
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored, with no capture and no error.
REQ-024 No same-cycle accept in DONE: a new request SHALL be accepted no earlier than the cycle after the handshake.
REQ-025 Operand registers SHALL NOT change outside the IDLE accept edge; input changes during RUN SHALL NOT affect the result.
REQ-026 Counter wrap: k SHALL be ceil(log2(NIBBLES+1)) bits, SHALL clear on accept, and SHALL never wrap during RUN.
REQ-027 sum SHALL be driven from the result register in all states; its contents outside DONE are don't-care for the consumer.
REQ-028 Throughput SHALL be one operation per NIBBLES+2 cycles when out_ready is held high.

Reset
REQ-029 rst=1 SHALL force IDLE, counter 0, carry 0, sum 0, cout 0, overflow 0, out_valid 0, and busy 0; in_ready SHALL be 1 from the first cycle after reset.
REQ-030 rst during RUN or DONE SHALL abort the operation with no result output; rst SHALL take priority over every handshake.

Structure
REQ-031 A shared package adder_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the constant NIBBLE_W=4.
REQ-032 One sub-module, nibble_add4 (4-bit combinational add: a, b, cin -> s, cout), SHALL be instantiated once and reused every RUN cycle.

Verification
REQ-033 a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0x00000000, cout=1, overflow=0, out_valid 8 cycles after accept.
REQ-034 a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, overflow=0; a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-035 a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, overflow=1; a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, overflow=1.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and sum held constant, in_ready=0, a second in_valid ignored; out_ready=1 -> IDLE next cycle, second request then accepted.
REQ-037 rst asserted at RUN cycle 3 -> next cycle IDLE, all outputs 0, in_ready=1; a following request 0x12345678+0x11111111 -> sum=0x23456789.
REQ-038 Operands change every cycle during RUN -> result equals the captured operands only.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/nibble_add4.sv
// Purely combinational 4-bit adder slice with carry in and carry out.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    s     = total[3:0];
    cout  = total[4];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Add/subtract controller that reuses one 4-bit adder, one nibble per cycle,
// with a valid/ready request side and a valid/ready result side.
module nibble_serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W   = $clog2(NIBBLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0]    idx;
  logic [WIDTH-1:0]    a_sh, b_sh;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_c;

  // Counter sits at NIBBLES in DONE; clamp so the select never leaves the word.
  always_comb begin
    idx   = (cnt_q > LAST) ? LAST : cnt_q;
    a_sh  = a_q >> {idx, 2'b00};
    b_sh  = b_q >> {idx, 2'b00};
    nib_a = a_sh[NIBBLE_W-1:0];
    nib_b = b_sh[NIBBLE_W-1:0];
  end

  nibble_add4 u_add (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = nib_c;
        sum_d   = (sum_q & ~(WIDTH'(4'hF) << {idx, 2'b00})) | (WIDTH'(nib_s) << {idx, 2'b00});
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cout_d  = nib_c;
          ovf_d   = (nib_a[3] == nib_b[3]) && (nib_s[3] != nib_a[3]);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl at WIDTH=32.
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From just after an accepting edge, count edges until out_valid (bounded).
  task automatic wait_done(input bit scramble, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (scramble) begin
        a   = $urandom;
        b   = $urandom;
        sub = 1'($urandom_range(0, 1));
      end
      step();
      lat++;
    end
  endtask

  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                       input bit scramble, output int lat);
    a = ia; b = ib; sub = isub; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    wait_done(scramble, lat);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [31:0] es, input logic ec,
                              input logic eo, input int lat);
    n_checks++;
    if (sum !== es) begin
      n_fail++; $display("FAIL %s sum: got %h expected %h", name, sum, es);
    end
    n_checks++;
    if (cout !== ec) begin
      n_fail++; $display("FAIL %s cout: got %b expected %b", name, cout, ec);
    end
    n_checks++;
    if (overflow !== eo) begin
      n_fail++; $display("FAIL %s overflow: got %b expected %b", name, overflow, eo);
    end
    n_checks++;
    if (lat != 8) begin
      n_fail++; $display("FAIL %s latency: got %0d expected 8", name, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy, cout, overflow} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset flags {rdy,vld,busy,cout,ovf}: got %b expected 10000",
               {in_ready, out_valid, busy, cout, overflow});
    end
    n_checks++;
    if (sum !== 32'h0) begin
      n_fail++; $display("FAIL reset sum: got %h expected 00000000", sum);
    end
  endtask

  task automatic test_add();
    int lat;
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    check_result("add_wrap", 32'h0000_0000, 1'b1, 1'b0, lat);
    finish_op();
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_fail++; $display("FAIL handshake_idle: got %b expected 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_sub();
    int lat;
    do_op(32'd5, 32'd7, 1'b1, 1'b0, lat);
    check_result("sub_5_7", 32'hFFFF_FFFE, 1'b0, 1'b0, lat);
    finish_op();
    do_op(32'd7, 32'd5, 1'b1, 1'b0, lat);
    check_result("sub_7_5", 32'h0000_0002, 1'b1, 1'b0, lat);
    finish_op();
  endtask

  task automatic test_overflow();
    int lat;
    do_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    check_result("ovf_add", 32'h8000_0000, 1'b0, 1'b1, lat);
    finish_op();
    do_op(32'h8000_0000, 32'h1, 1'b1, 1'b0, lat);
    check_result("ovf_sub", 32'h7FFF_FFFF, 1'b1, 1'b1, lat);
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, lat);
    check_result("bp_first", 32'h0000_1234, 1'b0, 1'b0, lat);
    a = 32'h0000_0100; b = 32'h0000_0023; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({out_valid, in_ready, busy} !== 3'b101 || sum !== 32'h0000_1234) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got vld/rdy/busy=%b sum=%h expected 101 sum=00001234",
                 i, {out_valid, in_ready, busy}, sum);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_fail++; $display("FAIL bp_release: got %b expected 100", {in_ready, out_valid, busy});
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_second_accept busy: got %b expected 1", busy);
    end
    wait_done(1'b0, lat);
    check_result("bp_second", 32'h0000_0123, 1'b0, 1'b0, lat);
    finish_op();
  endtask

  task automatic test_rst_abort();
    int lat;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy, cout, overflow} !== 5'b10000 || sum !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_abort: got flags=%b sum=%h expected 10000 sum=00000000",
               {in_ready, out_valid, busy, cout, overflow}, sum);
    end
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
    check_result("after_rst", 32'h2345_6789, 1'b0, 1'b0, lat);
    finish_op();
  endtask

  task automatic test_scramble();
    int lat;
    do_op(32'h89AB_CDEF, 32'h1234_5678, 1'b0, 1'b1, lat);
    check_result("scramble_add", 32'h9BE0_2467, 1'b0, 1'b0, lat);
    finish_op();
    do_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, lat);
    check_result("scramble_sub", 32'h0123_4567, 1'b1, 1'b0, lat);
    finish_op();
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    first = -1; second = -1;
    a = 32'h1; b = 32'h2; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (in_valid && in_ready) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    out_ready = 1'b0;
    n_checks++;
    if (first < 0 || second < 0 || (second - first) != 10) begin
      n_fail++;
      $display("FAIL throughput: got accepts at %0d and %0d expected 10 cycles apart",
               first, second);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_rst_abort();
    test_scramble();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
